trackball_step_encoder: RTL and testbench
=========================================

// Module: trackball_step_encoder
// PURPOSE
//  Converts PS/2 mouse packets and digital/analog joystick input into per-axis
//  dir/clk step pairs that emulate the cabinet trackball optics (htb_*/vtb_*).
//  Sits between hps_io and the missile core trackball inputs. Signed motion is
//  accumulated per axis, then drained one step at a time at a bounded rate.
// PARAMETERS
//  ACC_W     14    signed accumulator width per axis; fixed point with 2 fraction bits, 1 step = 4 units
//  STEP_DIV  1024  clk_sys cycles between consecutive steps on one axis, min 4
//  JOY_DIV   8192  clk_sys cycles between joystick injections
//  DEADZONE  8     analog magnitude at or below this is treated as 0
// PORTS
//  clk_sys          in   1   system clock (10 MHz)
//  reset_n          in   1   asynchronous active-low reset
//  ps2_mouse        in   25  [24] toggles per packet, [4]/[5] X/Y sign, [15:8] X, [23:16] Y
//  joystick         in   4   {up,down,left,right}, active high
//  joystick_analog  in   16  [7:0] X, [15:8] Y, two's complement
//  joystick_mode    in   1   0=digital, 1=analog
//  joy_sens         in   1   0=low, 1=high joystick speed
//  mouse_speed      in   2   0=25%, 1=50%, 2=100%, 3=200%
//  flip             in   1   invert both output directions
//  h_dir, h_clk     out  1   horizontal step direction / step clock
//  v_dir, v_clk     out  1   vertical step direction / step clock
// BEHAVIOUR
//  - Reset: accumulators=0; h_dir=v_dir=h_clk=v_clk=0; dividers=0; packet toggle latch = ps2_mouse[24].
//  - Packet detect: ps2_mouse[24] differs from latch -> one-cycle event, latch updates.
//  - Mouse delta: 9-bit signed {sign,byte}, shifted left by mouse_speed
//    (25%=x1, 50%=x2, 100%=x4, 200%=x8). Y is negated (PS/2 up = +).
//  - Digital joystick, once per JOY_DIV tick: add ±8 (low) or ±16 (high) per pressed axis;
//    opposite directions together add 0. Ignored when joystick_mode=1.
//  - Analog joystick, once per JOY_DIV tick, when joystick_mode=1: add value>>>2 (low) or
//    value>>>1 (high); |value|<=DEADZONE adds 0.
//  - Mouse and joystick contributions in the same cycle are summed, then added.
//  - Accumulator saturates at +/-(2^(ACC_W-1)-1); it never wraps.
//  - Per-axis step FSM: IDLE -> SETUP -> TOGGLE -> HOLD -> IDLE.
//    IDLE: if acc>=4 or acc<=-4, compute dir = (acc<0) XOR flip.
//      If dir equals the current output, go to TOGGLE; otherwise drive the new dir and go to SETUP.
//    SETUP: one cycle so dir settles before the clk edge -> TOGGLE.
//    TOGGLE: invert clk; acc -= 4 (or acc += 4 if negative) in the same cycle -> HOLD.
//    HOLD: wait STEP_DIV-2 cycles -> IDLE.
//  - Step period is therefore STEP_DIV cycles (+1 on a dir change). clk is a 50% toggle,
//    not a pulse; each edge is one count.
//  - Inputs arriving during SETUP/TOGGLE/HOLD still accumulate; no motion is lost except by saturation.
//  - A flip change takes effect at the next IDLE decision and uses the SETUP path.
//  - Fractional residue (|acc|<4) is held indefinitely; it is not cleared.
//  - reset_n asserted mid-step: all state is cleared immediately and pending motion is discarded.
// CONFIGURATION
//  TRACKBALL_ANALOG_EN defined: analog path as above.
//  Not defined: joystick_analog and joystick_mode are ignored, the digital joystick path is
//    always active, and no analog logic is synthesised.
// TESTING
//  - Reset, mouse_speed=2, one packet X=+3: 3 h_clk edges, STEP_DIV apart; h_dir=0; v_clk static.
//  - Packet X=-1 while the last +X step is in HOLD: SETUP cycle, h_dir=1 one cycle before the
//    h_clk edge; exactly 1 edge; acc returns to 0.
//  - mouse_speed=0, 3 packets X=+1: acc=3, no step; 4th packet -> 1 step, acc=0.
//  - Digital up held, joy_sens=1, 4*JOY_DIV cycles: 16 v_clk edges total, dir consistent;
//    flip=1 mid-run inverts v_dir only via SETUP.
//  - 50 packets X=+127 at mouse_speed=3: acc saturates at 8191 and never goes negative;
//    assert reset_n mid-HOLD: all outputs 0 within one cycle.
//  - (TRACKBALL_ANALOG_EN) joystick_mode=1, X=+6: no steps; X=+64 low sens: +16 per tick,
//    4 steps per tick period.

Source files
------------

// File: rtl/trackball_step_encoder.sv
// trackball_step_encoder
//   Turns PS/2 mouse packets and joystick input into per-axis dir/clk step
//   pairs that imitate the cabinet trackball optics. Motion is summed into a
//   signed fixed-point accumulator per axis (2 fraction bits, 4 units = 1
//   step). A small per-axis FSM then drains the accumulator one step at a
//   time, with at most one step every STEP_DIV cycles.
//
// Build option:
//   TRACKBALL_ANALOG_EN  When defined, joystick_mode=1 selects the analog
//                        stick. When not defined, joystick_analog and
//                        joystick_mode are ignored and only the digital
//                        joystick path is built.
//
// Ports:
//   clk_sys          system clock
//   reset_n          asynchronous active-low reset
//   ps2_mouse[24:0]  [24] packet toggle, [4]/[5] X/Y sign, [15:8] X, [23:16] Y
//   joystick[3:0]    {up, down, left, right}, active high
//   joystick_analog  [7:0] X, [15:8] Y, two's complement
//   joystick_mode    0 = digital, 1 = analog
//   joy_sens         0 = low, 1 = high joystick speed
//   mouse_speed      0..3 -> mouse delta x1, x2, x4, x8
//   flip             inverts both output directions
//   h_dir / h_clk    horizontal step direction / step clock (50% toggle)
//   v_dir / v_clk    vertical step direction / step clock
module trackball_step_encoder #(
  parameter int ACC_W    = 14,
  parameter int STEP_DIV = 1024,
  parameter int JOY_DIV  = 8192,
  parameter int DEADZONE = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [24:0] ps2_mouse,
  input  logic [3:0]  joystick,
  input  logic [15:0] joystick_analog,
  input  logic        joystick_mode,
  input  logic        joy_sens,
  input  logic [1:0]  mouse_speed,
  input  logic        flip,
  output logic        h_dir,
  output logic        h_clk,
  output logic        v_dir,
  output logic        v_clk
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_TOGGLE,
    ST_HOLD
  } step_state_t;

  // Working width for sums: accumulator plus headroom for one cycle's input.
  localparam int SW = ACC_W + 8;
  localparam int HW = $clog2(STEP_DIV);
  localparam int JW = $clog2(JOY_DIV);
  localparam logic signed [SW-1:0] ACC_MAX  = SW'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] ACC_MIN  = -ACC_MAX;
  localparam logic signed [SW-1:0] ONE_STEP = SW'(4);

  // ---------------------------------------------------------------------
  // Mouse packet detection and delta scaling
  // ---------------------------------------------------------------------
  logic pkt_tgl;
  logic pkt_evt;

  // The latch takes the live toggle bit during reset, so a packet that is
  // already present when reset is released does not count as new.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) pkt_tgl <= ps2_mouse[24];
    else          pkt_tgl <= ps2_mouse[24];
  end

  assign pkt_evt = ps2_mouse[24] ^ pkt_tgl;

  logic signed [8:0]    mouse_x, mouse_y;
  logic signed [SW-1:0] mouse_dx, mouse_dy;

  assign mouse_x = {ps2_mouse[4], ps2_mouse[15:8]};
  assign mouse_y = {ps2_mouse[5], ps2_mouse[23:16]};

  always_comb begin
    mouse_dx = '0;
    mouse_dy = '0;
    if (pkt_evt) begin
      mouse_dx = SW'(mouse_x) <<< mouse_speed;
      // PS/2 reports up as positive; the optics count up as negative.
      mouse_dy = -(SW'(mouse_y) <<< mouse_speed);
    end
  end

  // ---------------------------------------------------------------------
  // Joystick injection
  // ---------------------------------------------------------------------
  logic [JW-1:0] joy_div;
  logic          joy_tick;

  assign joy_tick = (joy_div == JW'(JOY_DIV - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)      joy_div <= '0;
    else if (joy_tick) joy_div <= '0;
    else               joy_div <= joy_div + 1'b1;
  end

  logic signed [SW-1:0] joy_step, dig_dx, dig_dy, joy_dx, joy_dy;

  assign joy_step = joy_sens ? SW'(16) : SW'(8);

  // Opposite directions pressed together cancel out.
  always_comb begin
    dig_dx = '0;
    dig_dy = '0;
    if (joystick[0] && !joystick[1]) dig_dx = joy_step;
    if (joystick[1] && !joystick[0]) dig_dx = -joy_step;
    if (joystick[2] && !joystick[3]) dig_dy = joy_step;
    if (joystick[3] && !joystick[2]) dig_dy = -joy_step;
  end

`ifdef TRACKBALL_ANALOG_EN
  function automatic logic signed [SW-1:0] analog_term(input logic [7:0] raw,
                                                       input logic       sens);
    logic signed [SW-1:0] ext;
    logic signed [SW-1:0] mag;
    ext = SW'(signed'(raw));
    mag = (ext < 0) ? -ext : ext;
    if (mag <= SW'(DEADZONE)) return '0;
    return sens ? (ext >>> 1) : (ext >>> 2);
  endfunction

  logic signed [SW-1:0] ana_dx, ana_dy;

  assign ana_dx = analog_term(joystick_analog[7:0], joy_sens);
  assign ana_dy = analog_term(joystick_analog[15:8], joy_sens);

  assign joy_dx = joy_tick ? (joystick_mode ? ana_dx : dig_dx) : '0;
  assign joy_dy = joy_tick ? (joystick_mode ? ana_dy : dig_dy) : '0;

  logic unused_bits;
  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:0]};
`else
  assign joy_dx = joy_tick ? dig_dx : '0;
  assign joy_dy = joy_tick ? dig_dy : '0;

  logic unused_bits;
  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:0], joystick_analog, joystick_mode};
`endif

  // ---------------------------------------------------------------------
  // Per-axis accumulator and step FSM (index 0 = horizontal, 1 = vertical)
  // ---------------------------------------------------------------------
  step_state_t             st_q     [2];
  step_state_t             st_d     [2];
  logic signed [ACC_W-1:0] acc_q    [2];
  logic signed [ACC_W-1:0] acc_d    [2];
  logic                    dir_q    [2];
  logic                    dir_d    [2];
  logic                    sclk_q   [2];
  logic                    sclk_d   [2];
  logic [HW-1:0]           hold_q   [2];
  logic [HW-1:0]           hold_d   [2];
  logic signed [SW-1:0]    in_delta [2];
  logic signed [SW-1:0]    acc_ext  [2];
  logic signed [SW-1:0]    step_adj [2];
  logic signed [SW-1:0]    acc_sum  [2];
  logic                    want_dir [2];

  assign in_delta[0] = mouse_dx + joy_dx;
  assign in_delta[1] = mouse_dy + joy_dy;

  always_comb begin
    for (int unsigned ax = 0; ax < 2; ax++) begin
      st_d[ax]     = st_q[ax];
      dir_d[ax]    = dir_q[ax];
      sclk_d[ax]   = sclk_q[ax];
      hold_d[ax]   = hold_q[ax];
      step_adj[ax] = '0;
      acc_ext[ax]  = SW'(acc_q[ax]);
      want_dir[ax] = acc_q[ax][ACC_W-1] ^ flip;

      case (st_q[ax])
        ST_IDLE: begin
          if (acc_ext[ax] >= ONE_STEP || acc_ext[ax] <= -ONE_STEP) begin
            if (want_dir[ax] == dir_q[ax]) begin
              st_d[ax] = ST_TOGGLE;
            end else begin
              dir_d[ax] = want_dir[ax];
              st_d[ax]  = ST_SETUP;
            end
          end
        end
        ST_SETUP: st_d[ax] = ST_TOGGLE;
        ST_TOGGLE: begin
          sclk_d[ax]   = ~sclk_q[ax];
          step_adj[ax] = (acc_ext[ax] < 0) ? ONE_STEP : -ONE_STEP;
          hold_d[ax]   = '0;
          st_d[ax]     = ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_q[ax] == HW'(STEP_DIV - 3)) st_d[ax] = ST_IDLE;
          else                                 hold_d[ax] = hold_q[ax] + 1'b1;
        end
        default: st_d[ax] = ST_IDLE;
      endcase

      // New input and the step debit land in one sum, saturated once, so a
      // step taken while the accumulator is pinned does not free headroom.
      acc_sum[ax] = acc_ext[ax] + in_delta[ax] + step_adj[ax];
      if (acc_sum[ax] > ACC_MAX)      acc_d[ax] = ACC_W'(ACC_MAX);
      else if (acc_sum[ax] < ACC_MIN) acc_d[ax] = ACC_W'(ACC_MIN);
      else                            acc_d[ax] = ACC_W'(acc_sum[ax]);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    for (int unsigned ax = 0; ax < 2; ax++) begin
      if (!reset_n) begin
        st_q[ax]   <= ST_IDLE;
        acc_q[ax]  <= '0;
        dir_q[ax]  <= 1'b0;
        sclk_q[ax] <= 1'b0;
        hold_q[ax] <= '0;
      end else begin
        st_q[ax]   <= st_d[ax];
        acc_q[ax]  <= acc_d[ax];
        dir_q[ax]  <= dir_d[ax];
        sclk_q[ax] <= sclk_d[ax];
        hold_q[ax] <= hold_d[ax];
      end
    end
  end

  assign h_dir = dir_q[0];
  assign h_clk = sclk_q[0];
  assign v_dir = dir_q[1];
  assign v_clk = sclk_q[1];

endmodule

// File: tb/tb_trackball_step_encoder.sv
// Testbench for trackball_step_encoder. Expected step edges are queued per
// axis when stimulus is issued; a monitor on the falling clock edge pops an
// entry for every h_clk/v_clk edge and checks direction, spacing and that
// the direction was already stable one cycle before the edge.
module tb_trackball_step_encoder;

  localparam int STEP = 8;
  localparam int JDIV = 128;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [24:0] ps2_mouse = '0;
  logic [3:0]  joystick = '0;
  logic [15:0] joystick_analog = '0;
  logic        joystick_mode = 1'b0;
  logic        joy_sens = 1'b0;
  logic [1:0]  mouse_speed = 2'd2;
  logic        flip = 1'b0;
  logic        h_dir, h_clk, v_dir, v_clk;

  always #5 clk_sys = ~clk_sys;

  trackball_step_encoder #(
    .ACC_W   (14),
    .STEP_DIV(STEP),
    .JOY_DIV (JDIV),
    .DEADZONE(8)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ps2_mouse      (ps2_mouse),
    .joystick       (joystick),
    .joystick_analog(joystick_analog),
    .joystick_mode  (joystick_mode),
    .joy_sens       (joy_sens),
    .mouse_speed    (mouse_speed),
    .flip           (flip),
    .h_dir          (h_dir),
    .h_clk          (h_clk),
    .v_dir          (v_dir),
    .v_clk          (v_clk)
  );

  typedef struct {
    logic        dir;
    int unsigned gap;   // 0 = spacing not checked
    bit          pre;   // dir must already match one cycle before the edge
  } exp_t;

  exp_t q_h[$];
  exp_t q_v[$];

  int          checks = 0;
  int          failures = 0;
  bit          bypass_h = 1'b0;
  int unsigned cyc = 0, last_h = 0, last_v = 0, edges_h = 0, edges_v = 0;
  logic        hclk_s, vclk_s, hdir_s, vdir_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_edge(input int axis, input logic d, input logic d_prev,
                            input int unsigned gap);
    exp_t  e;
    string nm;
    nm = (axis == 0) ? "h" : "v";
    if (axis == 0 && bypass_h) begin
      chk("h_burst_dir", 32'(d), 32'd0);
      return;
    end
    if ((axis == 0 && q_h.size() == 0) || (axis == 1 && q_v.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected_edge: got edge at cycle %0d expected none", nm, cyc);
      return;
    end
    if (axis == 0) e = q_h.pop_front();
    else           e = q_v.pop_front();
    chk({nm, "_edge_dir"}, 32'(d), 32'(e.dir));
    if (e.gap != 0) chk({nm, "_edge_gap"}, gap, e.gap);
    if (e.pre)      chk({nm, "_dir_setup"}, 32'(d_prev), 32'(e.dir));
  endtask

  // Monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk_sys) begin
    cyc++;
    if (reset_n) begin
      if (h_clk !== hclk_s) begin
        check_edge(0, h_dir, hdir_s, cyc - last_h);
        last_h = cyc;
        edges_h++;
      end
      if (v_clk !== vclk_s) begin
        check_edge(1, v_dir, vdir_s, cyc - last_v);
        last_v = cyc;
        edges_v++;
      end
    end
    hclk_s = h_clk;
    vclk_s = v_clk;
    hdir_s = h_dir;
    vdir_s = v_dir;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic exp_h(input logic d, input int unsigned g, input bit p);
    exp_t e;
    e.dir = d; e.gap = g; e.pre = p;
    q_h.push_back(e);
  endtask

  task automatic exp_v(input logic d, input int unsigned g, input bit p);
    exp_t e;
    e.dir = d; e.gap = g; e.pre = p;
    q_v.push_back(e);
  endtask

  task automatic send_pkt(input logic signed [8:0] x, input logic signed [8:0] y);
    ps2_mouse[15:8]  = x[7:0];
    ps2_mouse[4]     = x[8];
    ps2_mouse[23:16] = y[7:0];
    ps2_mouse[5]     = y[8];
    ps2_mouse[24]    = ~ps2_mouse[24];
    tick(1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((q_h.size() != 0 || q_v.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (q_h.size() != 0 || q_v.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d pending edges expected 0", name,
               q_h.size() + q_v.size());
      q_h.delete();
      q_v.delete();
    end
    tick(3 * STEP);
  endtask

  task automatic wait_h_edge(input string name, input int unsigned base);
    int unsigned n;
    n = 0;
    while (edges_h == base && n < 4 * STEP) begin
      tick(1);
      n++;
    end
    chk(name, edges_h - base, 32'd1);
  endtask

  int unsigned base_h, base_v;

  initial begin
    tick(2);
    do_reset();
    tick(1);

    // Reset state
    chk("rst_h_dir", 32'(h_dir), 32'd0);
    chk("rst_h_clk", 32'(h_clk), 32'd0);
    chk("rst_v_dir", 32'(v_dir), 32'd0);
    chk("rst_v_clk", 32'(v_clk), 32'd0);

    // X=+3 at x4: three +X edges STEP apart, vertical quiet
    exp_h(1'b0, 0, 1'b0);
    exp_h(1'b0, STEP, 1'b0);
    exp_h(1'b0, STEP, 1'b0);
    send_pkt(9'sd3, 9'sd0);
    wait_drain("t1", 8 * STEP);
    chk("t1_h_dir", 32'(h_dir), 32'd0);

    // X=+1, then X=-1 while that step is in HOLD: reversal through SETUP
    base_h = edges_h;
    exp_h(1'b0, 0, 1'b0);
    exp_h(1'b1, STEP + 1, 1'b1);
    send_pkt(9'sd1, 9'sd0);
    wait_h_edge("t2_first_edge", base_h);
    send_pkt(-9'sd1, 9'sd0);
    wait_drain("t2", 8 * STEP);
    chk("t2_h_dir", 32'(h_dir), 32'd1);
    chk("t2_edges", edges_h - base_h, 32'd2);

    // x1 scaling: three +1 packets leave residue 3, the fourth makes a step
    mouse_speed = 2'd0;
    base_h = edges_h;
    for (int i = 0; i < 3; i++) begin
      send_pkt(9'sd1, 9'sd0);
      tick(2);
    end
    tick(4 * STEP);
    chk("t3_residue_no_step", edges_h - base_h, 32'd0);
    exp_h(1'b0, 0, 1'b1);
    send_pkt(9'sd1, 9'sd0);
    wait_drain("t3", 8 * STEP);
    chk("t3_edges", edges_h - base_h, 32'd1);

    // Digital up, high speed: -16 per tick -> 4 steps per tick, 4 ticks
    mouse_speed = 2'd2;
    joy_sens    = 1'b1;
    joystick    = 4'b1000;
    base_v      = edges_v;
    base_h      = edges_h;
    for (int t = 0; t < 4; t++) begin
      if (t == 0 || t == 2) exp_v(t == 0 ? 1'b1 : 1'b0, 0, 1'b1);
      else                  exp_v(t == 1 ? 1'b1 : 1'b0, 0, 1'b0);
      for (int k = 0; k < 3; k++) exp_v(t < 2 ? 1'b1 : 1'b0, STEP, 1'b0);
    end
    do_reset();
    tick(2 * JDIV + JDIV / 2);
    flip = 1'b1;
    tick(4);
    chk("t4_flip_no_direct_effect", 32'(v_dir), 32'd1);
    tick(4 * JDIV + JDIV / 2 - (2 * JDIV + JDIV / 2) - 4);
    joystick = 4'b0000;
    wait_drain("t4", 4 * STEP);
    chk("t4_v_edges", edges_v - base_v, 32'd16);
    chk("t4_h_edges", edges_h - base_h, 32'd0);
    chk("t4_v_dir_flipped", 32'(v_dir), 32'd0);

    // Saturation: 50 x (+127 at x8) pins the accumulator at 8191
    flip        = 1'b0;
    mouse_speed = 2'd3;
    do_reset();
    tick(2);
    bypass_h = 1'b1;
    for (int i = 0; i < 50; i++) send_pkt(9'sd127, 9'sd0);
    @(negedge clk_sys);
    #1;
    bypass_h = 1'b0;
    exp_h(1'b0, 0, 1'b0);
    for (int i = 1; i < 2047; i++) exp_h(1'b0, STEP, 1'b0);
    base_h = edges_h;
    wait_drain("t5", 2047 * STEP + 8 * STEP);
    chk("t5_drained_edges", edges_h - base_h, 32'd2047);
    chk("t5_h_dir", 32'(h_dir), 32'd0);

    // Reset in the middle of HOLD discards everything
    mouse_speed = 2'd2;
    do_reset();
    tick(2);
    base_h = edges_h;
    exp_h(1'b1, 0, 1'b1);
    send_pkt(-9'sd3, 9'sd0);
    wait_h_edge("t6_first_edge", base_h);
    tick(2);
    chk("t6_pre_h_clk", 32'(h_clk), 32'd1);
    chk("t6_pre_h_dir", 32'(h_dir), 32'd1);
    reset_n = 1'b0;
    #2;
    chk("t6_rst_h_dir", 32'(h_dir), 32'd0);
    chk("t6_rst_h_clk", 32'(h_clk), 32'd0);
    chk("t6_rst_v_dir", 32'(v_dir), 32'd0);
    chk("t6_rst_v_clk", 32'(v_clk), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(6 * STEP);
    chk("t6_pending_discarded", edges_h - base_h, 32'd1);
    chk("t6_queue_empty", 32'(q_h.size()), 32'd0);

`ifdef TRACKBALL_ANALOG_EN
    // Analog: inside deadzone nothing; +64 low sens -> +16 per tick
    do_reset();
    joystick_mode   = 1'b1;
    joy_sens        = 1'b0;
    joystick_analog = 16'h0006;
    base_h = edges_h;
    tick(3 * JDIV);
    chk("t7_deadzone", edges_h - base_h, 32'd0);
    exp_h(1'b0, 0, 1'b0);
    for (int k = 0; k < 3; k++) exp_h(1'b0, STEP, 1'b0);
    joystick_analog = 16'h0040;
    tick(JDIV);
    joystick_analog = 16'h0000;
    wait_drain("t7", JDIV);
    chk("t7_edges_per_tick", edges_h - base_h, 32'd4);
    joystick_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
